// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller slice.
// Holds the default bus widths used by the controller and its clients, the
// pattern select codes understood by sram_pattern_gen, and the BIST FSM
// state encodings.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  // Test pattern codes (pattern_sel)
  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_CHK  = 2'd2;
  localparam logic [1:0] PAT_ONES = 2'd3;

  // BIST FSM states
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrWait = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdWait = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

endpackage

// File: rtl/sram_pattern_gen.sv
// Expected-data generator for the SRAM BIST.
// The pattern code is captured when load is high and held for the whole test,
// so the same expected(addr) drives both the write data and the read compare.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture sel into the pattern register
//   sel        : pattern code (PAT_ADDR, PAT_INV, PAT_CHK, PAT_ONES)
//   addr       : address to generate data for
//   expected   : combinational expected data for addr
module sram_pattern_gen
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] expected
);

  localparam int unsigned WideW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [1:0]        pat_q;
  logic [WideW-1:0]  addr_wide;
  logic [DATA_W-1:0] addr_data;
  logic [DATA_W-1:0] chk_hi;   // 0xAAAA.. replicated to DATA_W

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= PAT_ADDR;
    end else if (load) begin
      pat_q <= sel;
    end
  end

  // Widen first so the address is zero-extended or truncated to DATA_W.
  assign addr_wide = WideW'(addr);
  assign addr_data = addr_wide[DATA_W-1:0];

  always_comb begin
    chk_hi = '0;
    for (int i = 0; i < DATA_W; i++) begin
      chk_hi[i] = (i % 2) == 1;
    end
  end

  always_comb begin
    expected = addr_data;
    case (pat_q)
      PAT_ADDR: expected = addr_data;
      PAT_INV:  expected = ~addr_data;
      PAT_CHK:  expected = addr[0] ? chk_hi : ~chk_hi;
      PAT_ONES: expected = '1;
      default:  expected = addr_data;
    endcase
  end

endmodule

// File: rtl/sram_bist_client.sv
// SRAM BIST client: drives the user side of the SRAM controller with a
// write pass over 0..ADDR_LAST followed by a read-and-compare pass, then
// reports pass/fail, a saturating mismatch count and the first failing address.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : pulse; starts a test from idle or done
//   pattern_sel      : data pattern, latched at start
//   ready            : controller idle/accepting
//   data_s2f_r       : registered read data from the controller
//   mem, rw, addr    : request valid, 1=read/0=write, request address
//   data_f2s         : write data
//   busy, done, pass : status; pass is meaningful only with done
//   err_count        : mismatch count (saturating)
//   first_err_addr   : address of the first mismatch
//   timeout_err      : controller stopped responding
module sram_bist_client
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned ADDR_LAST = 255,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_s2f_r,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              tmo_q, tmo_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0] expected;
  logic              idle_like;
  logic              at_last;
  logic              timed_out;
  logic              in_test;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign in_test   = !idle_like;
  assign at_last   = addr_q == ADDR_W'(ADDR_LAST);
  assign timed_out = wcnt_q == CntW'(TIMEOUT - 1);

  sram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (start && idle_like),
    .sel      (pattern_sel),
    .addr     (addr_q),
    .expected (expected)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    tmo_d   = tmo_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrReq;
          addr_d  = '0;
          err_d   = '0;
          ferr_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      StWrReq: begin
        if (ready) begin
          state_d = StWrWait;
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWrWait: begin
        if (ready) begin
          if (at_last) begin
            addr_d  = '0;
            state_d = StRdReq;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StWrReq;
          end
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StRdReq: begin
        if (ready) begin
          state_d = StRdWait;
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StRdWait: begin
        if (ready) begin
          if (data_s2f_r != expected) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            // err_q saturates rather than wraps, so zero means no earlier miss.
            if (err_q == 16'd0) begin
              ferr_d = addr_q;
            end
          end
          if (at_last) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRdReq;
          end
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Wait counter restarts on every state entry; REQ and WAIT always
    // alternate, so a state change is the only way to enter one of them.
    if (state_d != state_q || !in_test) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = wcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem            = (state_q == StWrReq) || (state_q == StRdReq);
  assign rw             = !((state_q == StWrReq) || (state_q == StWrWait));
  assign addr           = addr_q;
  assign data_f2s       = expected;
  assign busy           = in_test;
  assign done           = state_q == StDone;
  assign pass           = done && (err_q == 16'd0) && !tmo_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_sram_bist_client.sv
// Self-checking bench for sram_bist_client with a behavioural controller
// responder. Expected requests are queued when a test is started and compared
// against the requests the responder actually saw.
module tb_sram_bist_client;

  localparam int unsigned AW   = 18;
  localparam int unsigned DW   = 16;
  localparam int unsigned LAST = 3;
  localparam int unsigned TMO  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    pattern_sel;
  logic          ready;
  logic [DW-1:0] data_s2f_r;
  logic          mem;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t obs_q[$];
  req_t exp_q[$];

  sram_bist_client #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ADDR_LAST (LAST),
    .TIMEOUT   (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .ready          (ready),
    .data_s2f_r     (data_s2f_r),
    .mem            (mem),
    .rw             (rw),
    .addr           (addr),
    .data_f2s       (data_f2s),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Controller responder: accepts when mem&&ready, drops ready for two cycles,
  // returns read data when ready comes back. resp_hold stops new acceptances.
  logic          resp_hold = 1'b0;
  logic          flip_en   = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [DW-1:0] mem_arr [0:255];
  bit            pend = 1'b0;
  int            lat  = 0;
  req_t          cur;

  initial begin
    ready      = 1'b1;
    data_s2f_r = '0;
  end

  always @(negedge clk) begin
    if (reset) begin
      ready = !resp_hold;
      pend  = 1'b0;
      lat   = 0;
    end else begin
      if (pend) begin
        pend  = 1'b0;
        ready = 1'b0;
        lat   = 2;
      end else if (lat > 0) begin
        lat = lat - 1;
        if (lat == 0) begin
          if (cur.rw) begin
            data_s2f_r = mem_arr[cur.a[7:0]];
            if (flip_en && cur.a == flip_addr) data_s2f_r = data_s2f_r ^ 16'h0008;
          end
          ready = 1'b1;
        end
      end else begin
        ready = !resp_hold;
      end
      if (ready && mem) begin
        pend   = 1'b1;
        cur.rw = rw;
        cur.a  = addr;
        cur.d  = data_f2s;
        obs_q.push_back(cur);
        if (!rw) mem_arr[addr[7:0]] = data_f2s;
      end
    end
  end

  function automatic logic [DW-1:0] model_pat(input int pat, input int a);
    logic [DW-1:0] v;
    v = DW'(a);
    case (pat)
      0:       return v;
      1:       return ~v;
      2:       return a[0] ? 16'hAAAA : 16'h5555;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic push_expected(input int pat);
    req_t e;
    for (int a = 0; a <= int'(LAST); a++) begin
      e.rw = 1'b0; e.a = AW'(a); e.d = model_pat(pat, a);
      exp_q.push_back(e);
    end
    for (int a = 0; a <= int'(LAST); a++) begin
      e.rw = 1'b1; e.a = AW'(a); e.d = model_pat(pat, a);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] pat);
    @(posedge clk); #1;
    pattern_sel = pat;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem, rw, busy, done, pass, timeout_err} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_ctl got mem/rw/busy/done/pass/tmo=%b want 010000",
               {mem, rw, busy, done, pass, timeout_err});
    end
    total++;
    if (err_count !== 16'd0 || first_err_addr !== '0 || addr !== '0) begin
      bad++;
      $display("FAIL reset_regs got err=%0h ferr=%0h addr=%0h want 0 0 0",
               err_count, first_err_addr, addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    req_t e, o;
    obs_q.delete(); exp_q.delete();
    push_expected(0);
    pulse_start(2'd0);
    wait_done(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL basic_done got no done want done"); end
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rw !== e.rw || o.a !== e.a || (!e.rw && o.d !== e.d)) begin
        bad++;
        $display("FAIL basic_req got rw=%0b a=%0h d=%0h want rw=%0b a=%0h d=%0h",
                 o.rw, o.a, o.d, e.rw, e.a, e.d);
      end
    end
    total++;
    if ({pass, timeout_err, busy} !== 3'b100 || err_count !== 16'd0) begin
      bad++;
      $display("FAIL basic_status got pass/tmo/busy=%b err=%0d want 100 0",
               {pass, timeout_err, busy}, err_count);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mismatch();
    bit ok;
    flip_en = 1'b1; flip_addr = AW'(2);
    obs_q.delete();
    pulse_start(2'd0);
    wait_done(ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL mism_done got no done want done"); end
    total++;
    if (err_count !== 16'd1 || first_err_addr !== AW'(2)) begin
      bad++;
      $display("FAIL mism_err got err=%0d ferr=%0h want 1 2", err_count, first_err_addr);
    end
    total++;
    if (pass !== 1'b0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL mism_pass got pass=%b tmo=%b want 0 0", pass, timeout_err);
    end
    flip_en = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_checker_restart();
    bit ok;
    req_t e, o;
    exp_q.delete(); obs_q.delete();
    push_expected(2);
    pulse_start(2'd2);
    @(negedge clk);
    total++;
    if (err_count !== 16'd0 || first_err_addr !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear got err=%0d ferr=%0h busy=%b want 0 0 1",
               err_count, first_err_addr, busy);
    end
    wait_done(ok);
    total++;
    if (ok !== 1'b1 || pass !== 1'b1) begin
      bad++; $display("FAIL chk_pass got done=%b pass=%b want 1 1", ok, pass);
    end
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL chk_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rw !== e.rw || o.a !== e.a || (!e.rw && o.d !== e.d)) begin
        bad++;
        $display("FAIL chk_req got rw=%0b a=%0h d=%0h want rw=%0b a=%0h d=%0h",
                 o.rw, o.a, o.d, e.rw, e.a, e.d);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int mem_cycles;
    @(posedge clk); #1;
    resp_hold = 1'b1;
    @(posedge clk);
    obs_q.delete();
    pulse_start(2'd0);
    mem_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (mem) mem_cycles++;
    end
    total++;
    if (ok !== 1'b1 || mem_cycles !== int'(TMO)) begin
      bad++;
      $display("FAIL tmo_len got done=%b req_cycles=%0d want 1 %0d", ok, mem_cycles, TMO);
    end
    total++;
    if ({timeout_err, pass, mem} !== 3'b100) begin
      bad++; $display("FAIL tmo_status got tmo/pass/mem=%b want 100", {timeout_err, pass, mem});
    end
    mem_cycles = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem) mem_cycles++;
    end
    total++;
    if (mem_cycles !== 0 || obs_q.size() !== 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL tmo_quiet got req_cycles=%0d accepted=%0d done=%b want 0 0 1",
               mem_cycles, obs_q.size(), done);
    end
    @(posedge clk); #1;
    resp_hold = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_busy_start_reset();
    bit ok;
    req_t e, o;
    exp_q.delete(); obs_q.delete();
    push_expected(0);
    pulse_start(2'd0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem && !rw && addr == AW'(1)) begin ok = 1'b1; break; end
    end
    // Stall acceptance so write 2 sits in its request state, and poke start.
    @(posedge clk); #1;
    resp_hold   = 1'b1;
    pattern_sel = 2'd3;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (mem && !rw && addr == AW'(2)) break;
      if (i == 199) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL busy_reach got no write 2 want write 2"); end
    total++;
    if (obs_q.size() !== 2) begin
      bad++; $display("FAIL busy_len got %0d want 2", obs_q.size());
    end
    for (int k = 0; k < 2 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rw !== e.rw || o.a !== e.a || o.d !== e.d) begin
        bad++;
        $display("FAIL busy_req got rw=%0b a=%0h d=%0h want rw=%0b a=%0h d=%0h",
                 o.rw, o.a, o.d, e.rw, e.a, e.d);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({mem, rw, busy, done} !== 4'b0100 || addr !== '0) begin
      bad++;
      $display("FAIL midreset got mem/rw/busy/done=%b addr=%0h want 0100 0",
               {mem, rw, busy, done}, addr);
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    resp_hold = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (obs_q.size() !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset got accepted=%0d busy=%b want 0 0", obs_q.size(), busy);
    end
    exp_q.delete(); obs_q.delete();
    push_expected(0);
    pulse_start(2'd0);
    wait_done(ok);
    total++;
    if (ok !== 1'b1 || pass !== 1'b1 || obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL rerun got done=%b pass=%b len=%0d want 1 1 %0d",
               ok, pass, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.rw !== e.rw || o.a !== e.a || (!e.rw && o.d !== e.d)) begin
        bad++;
        $display("FAIL rerun_req got rw=%0b a=%0h d=%0h want rw=%0b a=%0h d=%0h",
                 o.rw, o.a, o.d, e.rw, e.a, e.d);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern_sel = 2'd0;
    test_reset();
    test_basic();
    test_mismatch();
    test_checker_restart();
    test_timeout();
    test_busy_start_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
